// File: rtl/serial_neg_pkg.sv
// -----------------------------------------------------------------------------
// serial_neg_pkg
//
// Shared definitions for the bit-serial two's-complement negator.
//   MODE_PASS / MODE_NEG : per-word mode encoding carried on i_mode
//   frame_state_t        : word framing state (no word open / word open)
//   counter_width()      : width of the bit index counter for a given WIDTH
// -----------------------------------------------------------------------------
package serial_neg_pkg;

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_NEG  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } frame_state_t;

    // The bit index only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    // Widths below 2 are illegal; they are clamped so the counter never
    // collapses to zero bits.
    function automatic int counter_width(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_neg_lane.sv
// -----------------------------------------------------------------------------
// serial_neg_lane
//
// One serial lane of the negator. Holds the per-lane "seen a one" flag and the
// registered output/overflow bits. Framing, bit counting and the mode latch
// live in the top level and are shared by every lane.
//
// Ports:
//   t_clk     in   clock, rising edge
//   r         in   asynchronous active-high reset
//   bit_en    in   a data bit of an open (or just opening) word is present
//   word_open in   this bit is bit 0 of a new word; the seen-one flag restarts
//   mode      in   MODE_PASS or MODE_NEG for the word this bit belongs to
//   msb       in   this bit is the last (MSB) bit of the word
//   i         in   serial input bit
//   y         out  registered serial output bit
//   ovf       out  registered negation overflow, meaningful with the MSB only
// -----------------------------------------------------------------------------
module serial_neg_lane
    import serial_neg_pkg::*;
(
    input  logic t_clk,
    input  logic r,
    input  logic bit_en,
    input  logic word_open,
    input  logic mode,
    input  logic msb,
    input  logic i,
    output logic y,
    output logic ovf
);

    logic seen_one;
    logic seen_prev;

    // The flag value that applies to the current bit. On the opening bit the
    // previous word's flag is irrelevant, so it is forced clear here rather
    // than needing a separate clearing cycle between back-to-back words.
    always_comb begin
        seen_prev = word_open ? 1'b0 : seen_one;
    end

    // Negation LSB first: copy bits up to and including the first one, then
    // invert everything after it. Overflow is the most negative value, i.e. no
    // one seen before a one in the MSB position. The overflow register is only
    // left set for the MSB cycle so it cannot linger into a following word.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            seen_one <= 1'b0;
            y        <= 1'b0;
            ovf      <= 1'b0;
        end else if (bit_en) begin
            y        <= (mode == MODE_NEG) ? (i ^ seen_prev) : i;
            ovf      <= (mode == MODE_NEG) && msb && !seen_prev && i;
            seen_one <= seen_prev | i;
        end else begin
            ovf      <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_negator.sv
// -----------------------------------------------------------------------------
// serial_negator
//
// Bit-serial two's-complement negate/pass unit for LANES parallel lanes of
// WIDTH-bit words, LSB first, sharing one word framing. Each result bit is
// registered, so it appears one clock after the edge that accepted it.
//
// Parameters:
//   WIDTH  bits per word (2..64)
//   LANES  number of parallel serial lanes
//
// Ports:
//   t_clk      in   clock, rising edge
//   r          in   asynchronous active-high reset
//   i_valid    in   input bits valid this cycle; low stalls everything
//   i_sof      in   marks bit 0 of a word (with i_valid)
//   i_mode     in   0 pass, 1 negate; taken on the i_sof bit
//   i          in   [LANES] serial input bits
//   y          out  [LANES] serial result bits
//   y_valid    out  y carries a valid bit
//   y_eow      out  y carries the MSB of a completed word
//   ovf        out  [LANES] negation overflow, valid with y_eow
//   frame_err  out  one-cycle pulse for a stray bit or a premature start
// -----------------------------------------------------------------------------
module serial_negator
    import serial_neg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic             i_mode,
    input  logic [LANES-1:0] i,
    output logic [LANES-1:0] y,
    output logic             y_valid,
    output logic             y_eow,
    output logic [LANES-1:0] ovf,
    output logic             frame_err
);

    localparam int            CW       = counter_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    frame_state_t  state;
    logic [CW-1:0] bit_idx;
    logic          mode_q;

    logic in_busy;
    logic word_open;
    logic bit_en;
    logic msb_bit;
    logic lane_mode;
    logic frame_bad;

    // Decode of the current input against the framing state. A start bit is
    // always accepted, even mid-word: the open word is simply dropped and the
    // new one begins on this very bit. The opening bit uses i_mode directly
    // because the mode latch only updates on that same edge.
    always_comb begin
        in_busy   = (state == ST_BUSY);
        word_open = i_valid && i_sof;
        bit_en    = i_valid && (i_sof || in_busy);
        msb_bit   = i_valid && !i_sof && in_busy && (bit_idx == LAST_IDX);
        lane_mode = word_open ? i_mode : mode_q;
        frame_bad = i_valid && (i_sof ? in_busy : !in_busy);
    end

    // Framing FSM, bit counter, mode latch and the shared output qualifiers.
    // With i_valid low nothing advances and y_valid drops for that cycle.
    // Because the opening bit sets the counter straight to 1, WIDTH = 2 goes
    // directly from the opening bit to the closing bit.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state     <= ST_IDLE;
            bit_idx   <= '0;
            mode_q    <= MODE_PASS;
            y_valid   <= 1'b0;
            y_eow     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            y_valid   <= bit_en;
            y_eow     <= msb_bit;
            frame_err <= frame_bad;
            if (word_open) begin
                state   <= ST_BUSY;
                bit_idx <= CW'(1);
                mode_q  <= i_mode;
            end else if (bit_en) begin
                if (bit_idx == LAST_IDX) begin
                    state   <= ST_IDLE;
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + CW'(1);
                end
            end
        end
    end

    // One lane datapath per serial lane; all lanes see identical control.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serial_neg_lane u_lane (
            .t_clk     (t_clk),
            .r         (r),
            .bit_en    (bit_en),
            .word_open (word_open),
            .mode      (lane_mode),
            .msb       (msb_bit),
            .i         (i[g]),
            .y         (y[g]),
            .ovf       (ovf[g])
        );
    end

endmodule

// File: tb/tb_serial_negator.sv
// -----------------------------------------------------------------------------
// tb_serial_negator
//
// Directed bench for serial_negator with WIDTH=8, LANES=2. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge, which is where
// the registered result of the bit just accepted becomes visible.
// -----------------------------------------------------------------------------
module tb_serial_negator;

    localparam int WIDTH = 8;
    localparam int LANES = 2;

    logic             t_clk;
    logic             r;
    logic             i_valid;
    logic             i_sof;
    logic             i_mode;
    logic [LANES-1:0] i;
    logic [LANES-1:0] y;
    logic             y_valid;
    logic             y_eow;
    logic [LANES-1:0] ovf;
    logic             frame_err;

    int checks;
    int errors;

    logic [15:0] cap0;
    logic [15:0] cap1;
    logic [15:0] valid_hist;
    logic [1:0]  last_ovf;
    int          cnt;
    int          eow_seen;
    int          eow_at;
    int          ferr_count;

    serial_negator #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) dut (
        .t_clk     (t_clk),
        .r         (r),
        .i_valid   (i_valid),
        .i_sof     (i_sof),
        .i_mode    (i_mode),
        .i         (i),
        .y         (y),
        .y_valid   (y_valid),
        .y_eow     (y_eow),
        .ovf       (ovf),
        .frame_err (frame_err)
    );

    // Free-running 10 ns clock.
    initial begin
        t_clk = 1'b0;
        forever #5 t_clk = ~t_clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Forget everything collected from previous cycles.
    task automatic clearCapture();
        cap0       = '0;
        cap1       = '0;
        valid_hist = '0;
        last_ovf   = '0;
        cnt        = 0;
        eow_seen   = 0;
        eow_at     = -1;
        ferr_count = 0;
    endtask

    // Drive one cycle of inputs and record what the DUT produced for it.
    task automatic applyStimulus(input logic v, input logic sof, input logic mode,
                                 input logic [1:0] d);
        @(negedge t_clk);
        i_valid = v;
        i_sof   = sof;
        i_mode  = mode;
        i       = d;
        @(posedge t_clk);
        #1;
        valid_hist = {valid_hist[14:0], y_valid};
        if (y_valid) begin
            if (cnt < 16) begin
                cap0[cnt] = y[0];
                cap1[cnt] = y[1];
            end
            cnt++;
        end
        if (y_eow) begin
            eow_seen++;
            eow_at   = cnt;
            last_ovf = ovf;
        end
        if (frame_err) ferr_count++;
    endtask

    // Send bits [first, last] of a word pair. i_mode carries the requested
    // mode only on the start bit and the opposite value elsewhere, so the
    // mode must come from the latch for the rest of the word.
    task automatic sendBits(input logic mode, input logic [7:0] w0, input logic [7:0] w1,
                            input int first, input int last, input logic use_sof);
        for (int b = first; b <= last; b++) begin
            applyStimulus(1'b1, use_sof && (b == 0), (b == 0) ? mode : ~mode,
                          {w1[b], w0[b]});
        end
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_mode  = 1'b0;
        i       = '0;
        clearCapture();

        // Reset values.
        r = 1'b1;
        #12;
        checkOutput("reset y", 32'(y), 32'h0);
        checkOutput("reset y_valid", 32'(y_valid), 32'h0);
        checkOutput("reset y_eow", 32'(y_eow), 32'h0);
        checkOutput("reset ovf", 32'(ovf), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        @(negedge t_clk);
        r = 1'b0;
        idleCycles(2);

        // Negate 0x05 / 0x01.
        clearCapture();
        sendBits(1'b1, 8'h05, 8'h01, 0, 7, 1'b1);
        checkOutput("neg05 lane0", 32'(cap0[7:0]), 32'hFB);
        checkOutput("neg01 lane1", 32'(cap1[7:0]), 32'hFF);
        checkOutput("neg05 bit count", 32'(cnt), 32'd8);
        checkOutput("neg05 eow count", 32'(eow_seen), 32'd1);
        checkOutput("neg05 eow position", 32'(eow_at), 32'd8);
        checkOutput("neg05 ovf", 32'(last_ovf), 32'h0);
        checkOutput("neg05 frame_err", 32'(ferr_count), 32'd0);
        idleCycles(1);

        // Most negative value overflows on lane0 only.
        clearCapture();
        sendBits(1'b1, 8'h80, 8'h00, 0, 7, 1'b1);
        checkOutput("neg80 lane0", 32'(cap0[7:0]), 32'h80);
        checkOutput("neg00 lane1", 32'(cap1[7:0]), 32'h00);
        checkOutput("neg80 eow count", 32'(eow_seen), 32'd1);
        checkOutput("neg80 ovf", 32'(last_ovf), 32'h1);
        idleCycles(1);

        // Pass word followed back-to-back by a negate word.
        clearCapture();
        sendBits(1'b0, 8'h5A, 8'hA5, 0, 7, 1'b1);
        checkOutput("pass lane0", 32'(cap0[7:0]), 32'h5A);
        checkOutput("pass lane1", 32'(cap1[7:0]), 32'hA5);
        checkOutput("pass eow count", 32'(eow_seen), 32'd1);
        checkOutput("pass ovf", 32'(last_ovf), 32'h0);
        clearCapture();
        sendBits(1'b1, 8'h5A, 8'h5A, 0, 7, 1'b1);
        checkOutput("b2b neg5A lane0", 32'(cap0[7:0]), 32'hA6);
        checkOutput("b2b neg5A lane1", 32'(cap1[7:0]), 32'hA6);
        checkOutput("b2b eow position", 32'(eow_at), 32'd8);
        checkOutput("b2b frame_err", 32'(ferr_count), 32'd0);
        idleCycles(1);

        // Negate with a three-cycle stall after bit 2.
        clearCapture();
        sendBits(1'b1, 8'h05, 8'h01, 0, 2, 1'b1);
        idleCycles(3);
        sendBits(1'b1, 8'h05, 8'h01, 3, 7, 1'b1);
        checkOutput("stall valid pattern", 32'(valid_hist[10:0]), 32'b11100011111);
        checkOutput("stall lane0", 32'(cap0[7:0]), 32'hFB);
        checkOutput("stall lane1", 32'(cap1[7:0]), 32'hFF);
        checkOutput("stall eow count", 32'(eow_seen), 32'd1);
        checkOutput("stall eow position", 32'(eow_at), 32'd8);
        idleCycles(1);

        // Premature start at bit 4, then a fresh word 0x03.
        clearCapture();
        sendBits(1'b1, 8'h77, 8'h77, 0, 3, 1'b1);
        checkOutput("abort partial eow", 32'(eow_seen), 32'd0);
        checkOutput("abort partial frame_err", 32'(ferr_count), 32'd0);
        clearCapture();
        sendBits(1'b1, 8'h03, 8'h03, 0, 0, 1'b1);
        checkOutput("abort frame_err pulse", 32'(frame_err), 32'h1);
        checkOutput("abort no eow", 32'(y_eow), 32'h0);
        sendBits(1'b1, 8'h03, 8'h03, 1, 7, 1'b1);
        checkOutput("restart lane0", 32'(cap0[7:0]), 32'hFD);
        checkOutput("restart lane1", 32'(cap1[7:0]), 32'hFD);
        checkOutput("restart eow count", 32'(eow_seen), 32'd1);
        checkOutput("restart eow position", 32'(eow_at), 32'd8);
        checkOutput("restart frame_err count", 32'(ferr_count), 32'd1);

        // Stray valid bit while idle.
        clearCapture();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b11);
        checkOutput("stray frame_err", 32'(frame_err), 32'h1);
        checkOutput("stray y_valid", 32'(y_valid), 32'h0);
        idleCycles(1);
        checkOutput("stray frame_err single", 32'(frame_err), 32'h0);

        // Asynchronous reset in the middle of a word.
        clearCapture();
        sendBits(1'b1, 8'h05, 8'h01, 0, 2, 1'b1);
        checkOutput("pre-reset y", 32'(y), 32'h2);
        checkOutput("pre-reset y_valid", 32'(y_valid), 32'h1);
        #2;
        i_valid = 1'b0;
        r = 1'b1;
        #1;
        checkOutput("async reset y", 32'(y), 32'h0);
        checkOutput("async reset y_valid", 32'(y_valid), 32'h0);
        checkOutput("async reset y_eow", 32'(y_eow), 32'h0);
        @(negedge t_clk);
        r = 1'b0;
        clearCapture();
        sendBits(1'b1, 8'h05, 8'h05, 0, 7, 1'b0);
        checkOutput("no-sof accepted bits", 32'(cnt), 32'd0);
        checkOutput("no-sof frame_err count", 32'(ferr_count), 32'd8);
        checkOutput("no-sof eow", 32'(eow_seen), 32'd0);
        clearCapture();
        sendBits(1'b1, 8'h05, 8'h05, 0, 7, 1'b1);
        checkOutput("post-reset lane0", 32'(cap0[7:0]), 32'hFB);
        checkOutput("post-reset lane1", 32'(cap1[7:0]), 32'hFB);
        checkOutput("post-reset eow position", 32'(eow_at), 32'd8);
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
